// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the adder/divider datapath.
//   WIDTH        operand width of the fixed-width adder and divider
//   div_state_e  sequencing states of the restoring divider
//   QUOT_DBZ     quotient reported when the divisor is zero
package arith_pkg;

    localparam int unsigned WIDTH = 16;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } div_state_e;

    localparam logic [WIDTH-1:0] QUOT_DBZ = 16'hFFFF;

endpackage

// File: rtl/cla_16.sv
// 16-bit carry-lookahead adder built from four 4-bit lookahead groups.
//   a, b  in   16  addends
//   cin   in   1   carry in
//   sum   out  16  a + b + cin (low 16 bits)
//   cout  out  1   carry out
//   p, g  out  1   block propagate / generate for a higher lookahead level
module cla_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout,
    output logic        p,
    output logic        g
);

    logic [15:0] bp;
    logic [15:0] bg;
    logic [3:0]  gp;
    logic [3:0]  gg;
    logic [4:0]  gc;
    logic [16:0] c;

    always_comb begin
        bp = a ^ b;
        bg = a & b;
        for (int k = 0; k < 4; k++) begin
            gp[k] = &bp[4*k +: 4];
            gg[k] = bg[4*k+3]
                  | (bp[4*k+3] & bg[4*k+2])
                  | (bp[4*k+3] & bp[4*k+2] & bg[4*k+1])
                  | (bp[4*k+3] & bp[4*k+2] & bp[4*k+1] & bg[4*k]);
        end

        // Group carries computed in parallel from cin, not rippled.
        gc[0] = cin;
        gc[1] = gg[0] | (gp[0] & cin);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & cin);
        p     = &gp;
        g     = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0]);
        gc[4] = g | (p & cin);

        c = '0;
        for (int k = 0; k < 4; k++) begin
            c[4*k] = gc[k];
            for (int i = 0; i < 3; i++) begin
                c[4*k+i+1] = bg[4*k+i] | (bp[4*k+i] & c[4*k+i]);
            end
        end
        c[16] = gc[4];

        sum  = bp ^ c[15:0];
        cout = c[16];
    end

endmodule

// File: rtl/seq_div16.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, MSB first.
// Each iteration does a trial subtraction R' - divisor on a cla_16 (a + ~b + 1).
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   start        in   1   request, sampled only in idle
//   dividend     in   16  numerator, captured on the accepting edge
//   divisor      in   16  denominator, captured on the accepting edge
//   busy         out  1   division in progress
//   done         out  1   one-cycle pulse, results valid
//   quotient     out  16  result, held until the next accepted start
//   remainder    out  16  result, held until the next accepted start
//   div_by_zero  out  1   divisor was zero, held with the results
module seq_div16
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 16  // cla_16 is fixed-width: only 16 works
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned ITER  = WIDTH;
    localparam int unsigned CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    // Partial remainder after an iteration is always < divisor, so its 17th
    // bit is zero and only 16 bits are stored; R' below carries the 17th bit.
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] trial_sum;
    logic             trial_cout;
    logic             accept;
    logic [WIDTH-1:0] rem_next;

    always_comb begin
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        // R'[16] set means R' >= 2^16 > divisor even when cout shows a borrow.
        accept    = rem_shift[WIDTH] | trial_cout;
        rem_next  = accept ? trial_sum : rem_shift[WIDTH-1:0];
    end

    cla_16 u_trial_sub (
        .a    (rem_shift[WIDTH-1:0]),
        .b    (~dvs_q),
        .cin  (1'b1),
        .sum  (trial_sum),
        .cout (trial_cout),
        .p    (),
        .g    ()
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        div_by_zero <= 1'b0;
                        dvs_q       <= divisor;
                        quo_q       <= dividend;
                        rem_q       <= '0;
                        cnt_q       <= '0;
                        if (divisor == '0) begin
                            quotient    <= QUOT_DBZ;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state_q     <= StDone;
                        end else begin
                            busy    <= 1'b1;
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    rem_q <= rem_next;
                    quo_q <= {quo_q[WIDTH-2:0], accept};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= {quo_q[WIDTH-2:0], accept};
                        remainder <= rem_next;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div16.sv
// Directed self-checking bench for seq_div16 with hand-computed results.
module tb_seq_div16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seq_div16 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // One division; edges are counted after the accepting edge, so a zero
    // divisor shows done right after the accepting edge (0) and a normal one 16
    // edges later. poke re-asserts start with other operands mid-run.
    task automatic run_div(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] eq, input logic [15:0] er, input logic edbz,
                           input bit poke);
        int edges;
        int busy_cnt;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'hA5A5;
        divisor  = 16'h0003;
        edges    = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && edges < 40) begin
            if (poke && edges == 5) begin
                start    = 1'b1;
                dividend = 16'd50;
                divisor  = 16'd3;
            end else if (poke && edges == 8) begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            edges++;
            if (busy) busy_cnt++;
        end
        start = 1'b0;
        check({name, ".done"}, 32'(done), 32'd1);
        check({name, ".latency"}, edges, (b == 16'd0) ? 32'd0 : 32'd16);
        check({name, ".busy_cycles"}, busy_cnt, (b == 16'd0) ? 32'd0 : 32'd16);
        check({name, ".quotient"}, 32'(quotient), 32'(eq));
        check({name, ".remainder"}, 32'(remainder), 32'(er));
        check({name, ".div_by_zero"}, 32'(div_by_zero), 32'(edbz));
        // start while in DONE must be ignored
        start    = 1'b1;
        dividend = 16'd9;
        divisor  = 16'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({name, ".done_pulse"}, 32'(done), 32'd0);
        check({name, ".no_accept_in_done"}, 32'(busy), 32'd0);
        check({name, ".held_quotient"}, 32'(quotient), 32'(eq));
    endtask

    task automatic check_zero(input string name);
        check({name, ".busy"}, 32'(busy), 32'd0);
        check({name, ".done"}, 32'(done), 32'd0);
        check({name, ".quotient"}, 32'(quotient), 32'd0);
        check({name, ".remainder"}, 32'(remainder), 32'd0);
        check({name, ".div_by_zero"}, 32'(div_by_zero), 32'd0);
    endtask

    initial begin
        int done_seen;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_div("100/7",     16'd100,   16'd7,     16'd14,    16'd2,     1'b0, 1'b0);
        run_div("ffff/1",    16'hFFFF,  16'h0001,  16'hFFFF,  16'h0000,  1'b0, 1'b0);
        run_div("ffff/ffff", 16'hFFFF,  16'hFFFF,  16'h0001,  16'h0000,  1'b0, 1'b0);
        run_div("ffff/8001", 16'hFFFF,  16'h8001,  16'h0001,  16'h7FFE,  1'b0, 1'b0);
        run_div("3/10",      16'd3,     16'd10,    16'd0,     16'd3,     1'b0, 1'b0);
        run_div("0/5",       16'd0,     16'd5,     16'd0,     16'd0,     1'b0, 1'b0);
        run_div("5/0",       16'd5,     16'd0,     16'hFFFF,  16'd5,     1'b1, 1'b0);
        run_div("50000/7",   16'd50000, 16'd7,     16'd7142,  16'd6,     1'b0, 1'b0);
        run_div("restart",   16'd100,   16'd7,     16'd14,    16'd2,     1'b0, 1'b1);

        // Reset mid-run at iteration 8
        @(negedge clk);
        start    = 1'b1;
        dividend = 16'd1000;
        divisor  = 16'd33;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("midrun.busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_zero("abort");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        check("abort.no_done", done_seen, 32'd0);

        run_div("1000/33",   16'd1000,  16'd33,    16'd30,    16'd10,    1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
